// File: rtl/mfcc_pkg.sv
// Constants and state type shared by the power-spectrum and mel filterbank stages.
package mfcc_pkg;
    localparam int NFFT_FULL = 512;
    localparam int NBINS     = NFFT_FULL / 2 + 1;
    localparam int PTR_W     = $clog2(NBINS) + 1;
    localparam int IN_W      = 16;
    localparam int SHIFT     = $clog2(NFFT_FULL);
    localparam int CNT_W     = SHIFT;

    typedef enum logic [1:0] {FILL, DRAIN, START, SERVE} ps_state_t;
endpackage

// File: rtl/bin_power.sv
// Two-stage pipeline: squares the complex sample, then sums, rounds and divides by NFFT.
module bin_power
    import mfcc_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_i,
    input  logic [PTR_W-1:0]       idx_i,
    input  logic signed [IN_W-1:0] re_i,
    input  logic signed [IN_W-1:0] im_i,
    output logic                   wr_en_o,
    output logic [PTR_W-2:0]       wr_idx_o,
    output logic [31:0]            wr_data_o
);
    localparam logic [32:0] ROUND = 33'(1) << (SHIFT - 1);

    logic              v1_q, v1_d;
    logic [PTR_W-1:0]  idx1_q, idx1_d;
    logic [31:0]       re_sq_q, re_sq_d;
    logic [31:0]       im_sq_q, im_sq_d;
    logic signed [31:0] re_ext, im_ext;
    logic [32:0]       sum;
    logic [32:0]       p33;

    always_comb begin
        re_ext  = 32'(re_i);
        im_ext  = 32'(im_i);
        v1_d    = valid_i;
        idx1_d  = idx_i;
        // -32768^2 = 2^30 still fits, so the signed product is safe to reuse as unsigned
        re_sq_d = re_ext * re_ext;
        im_sq_d = im_ext * im_ext;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            idx1_q  <= '0;
            re_sq_q <= '0;
            im_sq_q <= '0;
        end else begin
            v1_q    <= v1_d;
            idx1_q  <= idx1_d;
            re_sq_q <= re_sq_d;
            im_sq_q <= im_sq_d;
        end
    end

    always_comb begin
        sum       = {1'b0, re_sq_q} + {1'b0, im_sq_q} + ROUND;
        p33       = sum >> SHIFT;
        wr_data_o = p33[31:0];
        wr_en_o   = v1_q && (idx1_q < PTR_W'(NBINS));
        wr_idx_o  = idx1_q[PTR_W-2:0];
    end
endmodule

// File: rtl/power_spectrum.sv
// Captures one FFT frame as per-bin power, then serves it to the mel stage until released.
//   state | meaning
//   FILL  | accepting FFT samples
//   DRAIN | waiting for the last writes to leave the pipeline
//   START | one-cycle mel_start_o pulse
//   SERVE | buffer read-only, waiting for mel_done_i
module power_spectrum
    import mfcc_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fft_valid_i,
    output logic                   fft_ready_o,
    input  logic signed [IN_W-1:0] fft_re_i,
    input  logic signed [IN_W-1:0] fft_im_i,
    input  logic                   fft_last_i,
    output logic                   mel_start_o,
    input  logic [PTR_W-1:0]       prt_power_spectrum_frame,
    output logic [31:0]            value_power_spectrum_frame,
    input  logic                   mel_done_i,
    output logic                   frame_err_o,
    output logic                   busy_o
);
    ps_state_t         state_q, state_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic              err_q, err_d;
    logic              drain_q, drain_d;
    logic              accept;
    logic              wr_en;
    logic [PTR_W-2:0]  wr_idx;
    logic [31:0]       wr_data;
    logic [31:0]       frame_buf_q [NBINS];

    assign accept = fft_valid_i && (state_q == FILL);

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        err_d       = 1'b0;
        drain_d     = drain_q;
        fft_ready_o = 1'b0;
        mel_start_o = 1'b0;
        unique case (state_q)
            FILL: begin
                fft_ready_o = 1'b1;
                if (accept) begin
                    n_d = n_q + 1'b1;
                    if (fft_last_i && n_q == CNT_W'(NFFT_FULL - 1)) begin
                        state_d = DRAIN;
                        n_d     = '0;
                        drain_d = 1'b1;
                    end else if (fft_last_i || n_q == CNT_W'(NFFT_FULL - 1)) begin
                        err_d = 1'b1;
                        n_d   = '0;
                    end
                end
            end
            DRAIN: begin
                if (drain_q == 1'b0) state_d = START;
                else                 drain_d = drain_q - 1'b1;
            end
            START: begin
                mel_start_o = 1'b1;
                state_d     = SERVE;
            end
            SERVE: begin
                if (mel_done_i) begin
                    state_d = FILL;
                    n_d     = '0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            n_q     <= '0;
            err_q   <= 1'b0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            err_q   <= err_d;
            drain_q <= drain_d;
        end
    end

    assign frame_err_o = err_q;
    assign busy_o      = (state_q != FILL);

    bin_power u_bin_power (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (accept),
        .idx_i     (PTR_W'(n_q)),
        .re_i      (fft_re_i),
        .im_i      (fft_im_i),
        .wr_en_o   (wr_en),
        .wr_idx_o  (wr_idx),
        .wr_data_o (wr_data)
    );

    // Frame buffer contents are don't-care after reset, so no reset here
    always_ff @(posedge clk) begin
        if (wr_en) frame_buf_q[wr_idx] <= wr_data;
    end

    always_comb begin
        value_power_spectrum_frame = '0;
        if (prt_power_spectrum_frame < PTR_W'(NBINS))
            value_power_spectrum_frame = frame_buf_q[prt_power_spectrum_frame[PTR_W-2:0]];
    end
endmodule

// File: tb/tb_power_spectrum.sv
// Self-checking bench for power_spectrum: ramp, random, full-scale, backpressure, error and reset frames.
module tb_power_spectrum;
    import mfcc_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   fft_valid_i = 1'b0;
    logic                   fft_ready_o;
    logic signed [IN_W-1:0] fft_re_i = '0;
    logic signed [IN_W-1:0] fft_im_i = '0;
    logic                   fft_last_i = 1'b0;
    logic                   mel_start_o;
    logic [PTR_W-1:0]       prt = '0;
    logic [31:0]            value;
    logic                   mel_done_i = 1'b0;
    logic                   frame_err_o;
    logic                   busy_o;

    int checks = 0;
    int failures = 0;
    int start_cnt = 0;
    int err_cnt = 0;

    int          re_arr [NFFT_FULL];
    int          im_arr [NFFT_FULL];
    logic [31:0] model  [NBINS];

    typedef struct {
        logic [PTR_W-1:0] prt;
        logic [31:0]      exp;
    } rd_vec_t;
    rd_vec_t vecs [6];

    power_spectrum dut (
        .clk                        (clk),
        .rst                        (rst),
        .fft_valid_i                (fft_valid_i),
        .fft_ready_o                (fft_ready_o),
        .fft_re_i                   (fft_re_i),
        .fft_im_i                   (fft_im_i),
        .fft_last_i                 (fft_last_i),
        .mel_start_o                (mel_start_o),
        .prt_power_spectrum_frame   (prt),
        .value_power_spectrum_frame (value),
        .mel_done_i                 (mel_done_i),
        .frame_err_o                (frame_err_o),
        .busy_o                     (busy_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mel_start_o) start_cnt++;
        if (frame_err_o) err_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Power of each non-redundant bin, straight from (re^2+im^2)/NFFT rounded to nearest
    task automatic build_model();
        for (int k = 0; k < NBINS; k++) begin
            longint s;
            s = longint'(re_arr[k]) * re_arr[k] + longint'(im_arr[k]) * im_arr[k] + NFFT_FULL / 2;
            model[k] = 32'(s / NFFT_FULL);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < NFFT_FULL; i++) begin
            logic [15:0] r;
            r = 16'($urandom);
            re_arr[i] = int'($signed(r));
            r = 16'($urandom);
            im_arr[i] = int'($signed(r));
        end
        build_model();
    endtask

    task automatic send(input int nsamp, input int last_at);
        for (int i = 0; i < nsamp; i++) begin
            int guard;
            fft_valid_i = 1'b1;
            fft_re_i    = 16'(re_arr[i]);
            fft_im_i    = 16'(im_arr[i]);
            fft_last_i  = (i == last_at);
            guard = 0;
            while (!fft_ready_o && guard < 1000) begin
                tick();
                guard++;
            end
            if (guard >= 1000) begin
                chk("ready_timeout", 32'(fft_ready_o), 32'd1);
                break;
            end
            tick();
        end
        fft_valid_i = 1'b0;
        fft_last_i  = 1'b0;
    endtask

    // Called one cycle after the last accept; start must land on offset 3
    task automatic expect_start(input string name);
        int first;
        int hits;
        first = -1;
        hits  = 0;
        for (int k = 1; k <= 5; k++) begin
            if (mel_start_o) begin
                hits++;
                if (first < 0) first = k;
            end
            tick();
        end
        chk({name, "_start_latency"}, 32'(first), 32'd3);
        chk({name, "_start_pulses"}, 32'(hits), 32'd1);
        chk({name, "_busy_serve"}, 32'(busy_o), 32'd1);
    endtask

    task automatic read_all(input string name);
        for (int k = 0; k < NBINS; k++) begin
            prt = PTR_W'(k);
            #1;
            chk({name, "_bin"}, value, model[k]);
        end
    endtask

    task automatic release_frame();
        mel_done_i = 1'b1;
        tick();
        mel_done_i = 1'b0;
        chk("release_ready", 32'(fft_ready_o), 32'd1);
        chk("release_busy", 32'(busy_o), 32'd0);
    endtask

    initial begin
        int s0;
        int e0;

        rst = 1'b1;
        repeat (3) tick();
        chk("rst_start", 32'(mel_start_o), 32'd0);
        chk("rst_err", 32'(frame_err_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", 32'(fft_ready_o), 32'd1);

        // Ramp frame
        for (int i = 0; i < NFFT_FULL; i++) begin
            re_arr[i] = i;
            im_arr[i] = 0;
        end
        build_model();
        s0 = start_cnt;
        send(NFFT_FULL, NFFT_FULL - 1);
        expect_start("ramp");
        vecs[0] = '{prt: 10'd0,    exp: 32'd0};
        vecs[1] = '{prt: 10'd22,   exp: 32'd1};
        vecs[2] = '{prt: 10'd100,  exp: 32'd20};
        vecs[3] = '{prt: 10'd256,  exp: 32'd128};
        vecs[4] = '{prt: 10'd257,  exp: 32'd0};
        vecs[5] = '{prt: 10'd1023, exp: 32'd0};
        for (int v = 0; v < 6; v++) begin
            prt = vecs[v].prt;
            #1;
            chk($sformatf("ramp_read_%0d", vecs[v].prt), value, vecs[v].exp);
        end
        read_all("ramp");

        // Backpressure during SERVE
        for (int c = 0; c < 20; c++) begin
            fft_valid_i = 1'b1;
            fft_re_i    = 16'($urandom);
            fft_im_i    = 16'($urandom);
            fft_last_i  = c[0];
            mel_done_i  = 1'b0;
            tick();
            chk("bp_ready_low", 32'(fft_ready_o), 32'd0);
        end
        fft_valid_i = 1'b0;
        fft_last_i  = 1'b0;
        read_all("bp_hold");
        chk("ramp_single_start", 32'(start_cnt - s0), 32'd1);
        release_frame();

        // Random frame right after release
        fill_random();
        send(NFFT_FULL, NFFT_FULL - 1);
        expect_start("rand1");
        read_all("rand1");
        release_frame();

        // Full scale
        for (int i = 0; i < NFFT_FULL; i++) begin
            re_arr[i] = -32768;
            im_arr[i] = -32768;
        end
        send(NFFT_FULL, NFFT_FULL - 1);
        expect_start("fullscale");
        for (int k = 0; k < NBINS; k++) begin
            prt = PTR_W'(k);
            #1;
            chk("fullscale_bin", value, 32'h0040_0000);
        end
        release_frame();

        // Early last at n = 100
        fill_random();
        s0 = start_cnt;
        e0 = err_cnt;
        send(101, 100);
        chk("early_err_pulse", 32'(frame_err_o), 32'd1);
        chk("early_ready", 32'(fft_ready_o), 32'd1);
        tick();
        chk("early_err_clear", 32'(frame_err_o), 32'd0);
        chk("early_busy", 32'(busy_o), 32'd0);
        repeat (4) tick();
        chk("early_no_start", 32'(start_cnt - s0), 32'd0);
        fill_random();
        send(NFFT_FULL, NFFT_FULL - 1);
        expect_start("after_err");
        read_all("after_err");
        chk("after_err_starts", 32'(start_cnt - s0), 32'd1);
        chk("after_err_errs", 32'(err_cnt - e0), 32'd1);
        release_frame();

        // Reset while sample 300 is presented
        fill_random();
        s0 = start_cnt;
        send(300, -1);
        fft_valid_i = 1'b1;
        fft_re_i    = 16'(re_arr[300]);
        fft_im_i    = 16'(im_arr[300]);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fft_valid_i = 1'b0;
        chk("midrst_ready", 32'(fft_ready_o), 32'd1);
        chk("midrst_start", 32'(mel_start_o), 32'd0);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        repeat (5) tick();
        chk("midrst_no_start", 32'(start_cnt - s0), 32'd0);
        fill_random();
        send(NFFT_FULL, NFFT_FULL - 1);
        expect_start("after_rst");
        read_all("after_rst");
        chk("after_rst_starts", 32'(start_cnt - s0), 32'd1);

        // Out-of-range reads against the latest frame
        prt = 10'd257;
        #1;
        chk("oor_257", value, 32'd0);
        prt = 10'd1023;
        #1;
        chk("oor_1023", value, 32'd0);
        prt = 10'd256;
        #1;
        chk("inrange_256", value, model[256]);

        // mel_done outside SERVE is ignored
        release_frame();
        mel_done_i = 1'b1;
        tick();
        mel_done_i = 1'b0;
        chk("idle_done_ready", 32'(fft_ready_o), 32'd1);
        chk("idle_done_busy", 32'(busy_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/power_spectrum.md
Name: power_spectrum

Overview:
- Sits directly upstream of the mel filterbank stage in the MFCC chain.
- Accepts one streamed 512-point complex FFT frame and computes the scaled power (re²+im²)/NFFT for the 257 non-redundant bins.
- Stores the bins in a local frame buffer, then pulses mel_start_o and serves random-access combinational reads from the mel stage until that stage signals done.

Parameters:
NFFT_FULL, 512, FFT length; must be a power of two.
NBINS, NFFT_FULL/2+1 (257), number of stored bins.
IN_W, 16, signed width of fft_re_i / fft_im_i.
SHIFT, $clog2(NFFT_FULL) (9), right shift implementing /NFFT.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
fft_valid_i  in  1  FFT sample valid
fft_ready_o  out  1  block accepts a sample this cycle
fft_re_i  in  IN_W  signed real part
fft_im_i  in  IN_W  signed imaginary part
fft_last_i  in  1  marks sample NFFT_FULL-1 of the frame
mel_start_o  out  1  one-cycle pulse: frame buffer ready
prt_power_spectrum_frame  in  $clog2(NBINS)+1 (10)  bin read index from mel stage
value_power_spectrum_frame  out  32  power of indexed bin, combinational
mel_done_i  in  1  mel stage finished with the frame
frame_err_o  out  1  one-cycle pulse: malformed frame discarded
busy_o  out  1  high in every state except FILL

Behaviour:
- Reset: state = FILL, sample counter = 0, pipeline valids = 0. mel_start_o, frame_err_o and busy_o are 0. fft_ready_o is 1 in the cycle after rst deasserts. Buffer contents are undefined. Reset mid-frame abandons that frame.
- Accept condition: a sample is accepted when fft_valid_i && fft_ready_o. The counter n runs 0..NFFT_FULL-1.
- Per-bin pipeline (2 cycles):
  - Stage 1 registers re² and im², each 32-bit unsigned.
  - Stage 2 computes p = (re² + im² + (1<<(SHIFT-1))) >> SHIFT in 33-bit arithmetic and zero-extends p to 32 bits.
  - When n < NBINS, stage 2 writes p to buf[n]. Samples with n ≥ NBINS are accepted and dropped (conjugate half).
- States:
  - FILL: fft_ready_o = 1.
    - If the accepted sample has n == NFFT_FULL-1 and fft_last_i = 1, go to DRAIN.
    - If fft_last_i = 1 with n < NFFT_FULL-1, or n == NFFT_FULL-1 with fft_last_i = 0: pulse frame_err_o the next cycle, reset n to 0, stay in FILL. No mel_start_o is issued; partial writes are harmless.
  - DRAIN: fft_ready_o = 0. Wait 2 cycles for the pipeline to empty, then go to START.
  - START: mel_start_o = 1 for exactly this one cycle, then go to SERVE.
  - SERVE: fft_ready_o = 0, buffer is read-only. On mel_done_i = 1, go to FILL and reset n to 0. fft_ready_o = 1 the next cycle.
- Latency: mel_start_o is high exactly 3 cycles after the cycle that accepts the last sample.
- Read port: value_power_spectrum_frame = buf[prt] when prt < NBINS, else 0. The read is asynchronous, so it is valid in the same cycle the index is presented.
- mel_done_i outside SERVE is ignored.
- fft_valid_i while fft_ready_o = 0 leaves all state unchanged; upstream must hold the sample.
- Arithmetic cases: the full-scale value -32768 squares to 2^30, so no overflow. The maximum p is 0x00400000 with SHIFT = 9.

Decomposition:
- Package mfcc_pkg holds NFFT_FULL, NBINS, PTR_W = $clog2(NBINS)+1, and typedef enum logic [1:0] {FILL, DRAIN, START, SERVE} ps_state_t. The mel stage imports the same constants.
- Sub-module bin_power: the 2-stage square/sum/round/shift pipeline with valid and index passthrough.
- The top level holds the FSM, the counter, the NBINS×32 buffer and the read mux.

Test Plan:
- Ramp frame: re = n, im = 0 for n = 0..511, last on n = 511.
  - mel_start_o pulses once, 3 cycles after the last accept.
  - Reads: bin 0 → 0, bin 22 → 1, bin 100 → 20, bin 256 → 128.
- Full scale: all samples re = im = -32768 → every bin 0..256 reads 0x00400000.
- Backpressure: drive fft_valid_i continuously through SERVE.
  - fft_ready_o stays 0 and buffer reads are unchanged.
  - Pulse mel_done_i: ready = 1 on the next cycle and the next frame captures correctly.
- Early last: fft_last_i at n = 100.
  - frame_err_o pulses one cycle, no mel_start_o, state stays FILL.
  - A following good frame completes normally.
- Reset mid-capture: assert rst at n = 300.
  - mel_start_o = 0, fft_ready_o = 1 after release.
  - A following full frame produces correct results and a single start pulse.
- Out-of-range reads: prt = 257 and prt = 1023 → 0. prt = 256 → the stored bin 256 value.
